hazard_forwarding_unit: RTL and testbench

HAZARD_FORWARDING_UNIT -- requirements
Module: hazard_forwarding_unit

---
 rtl/hazard_forwarding_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_forwarding_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// Forward selects and stall/flush controls are combinational from the current
// pipeline-register contents. The hazard FSM state and the saturating event
// counters are registered.
module hazard_forwarding_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rw,
    input  logic [4:0]  mem_rw,
    input  logic [4:0]  wb_rw,
    input  logic        ex_rf_enable,
    input  logic        mem_rf_enable,
    input  logic        wb_rf_enable,
    input  logic        ex_load,
    input  logic        ex_branch_taken,
    output logic        pc_load_enable,
    output logic        if_id_load_enable,
    output logic        if_id_hazard_reset,
    output logic        id_ex_hazard_reset,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [1:0]  hazard_state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // A stage supplies a source register only if it writes the register file
    // and targets a nonzero register; r0 is hardwired and never forwarded.
    function automatic logic reg_match(input logic       rf_en,
                                       input logic [4:0] rw,
                                       input logic [4:0] rs);
        return rf_en && (rw != 5'd0) && (rw == rs);
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, else register file.
    function automatic logic [1:0] fwd_select(input logic use_src,
                                              input logic ex_hit,
                                              input logic mem_hit,
                                              input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src) begin
            if (ex_hit)       sel = FWD_EX;
            else if (mem_hit) sel = FWD_MEM;
            else if (wb_hit)  sel = FWD_WB;
        end
        return sel;
    endfunction

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic ex_hit_a, mem_hit_a, wb_hit_a;
    logic ex_hit_b, mem_hit_b, wb_hit_b;
    logic load_use;

    // Register matching, forward selection, stall/flush decode and next state.
    always_comb begin
        ex_hit_a  = reg_match(ex_rf_enable,  ex_rw,  id_rs1);
        mem_hit_a = reg_match(mem_rf_enable, mem_rw, id_rs1);
        wb_hit_a  = reg_match(wb_rf_enable,  wb_rw,  id_rs1);
        ex_hit_b  = reg_match(ex_rf_enable,  ex_rw,  id_rs2);
        mem_hit_b = reg_match(mem_rf_enable, mem_rw, id_rs2);
        wb_hit_b  = reg_match(wb_rf_enable,  wb_rw,  id_rs2);

        load_use = ex_load && ((ex_hit_a && id_use_rs1) || (ex_hit_b && id_use_rs2));

        pc_load_enable     = 1'b1;
        if_id_load_enable  = 1'b1;
        if_id_hazard_reset = 1'b0;
        id_ex_hazard_reset = 1'b0;
        fwd_a_sel          = FWD_RF;
        fwd_b_sel          = FWD_RF;
        state_d            = ST_RUN;
        stall_count_d      = stall_count_q;
        flush_count_d      = flush_count_q;

        if (reset) begin
            // Outputs held at their idle values; any pending event is dropped.
            stall_count_d = 16'd0;
            flush_count_d = 16'd0;
        end else begin
            fwd_a_sel = fwd_select(id_use_rs1, ex_hit_a, mem_hit_a, wb_hit_a);
            fwd_b_sel = fwd_select(id_use_rs2, ex_hit_b, mem_hit_b, wb_hit_b);
            if (ex_branch_taken) begin
                // A taken branch kills the wrong-path instructions in IF/ID and
                // ID/EX; any load-use seen this cycle belongs to a killed
                // instruction and is ignored.
                if_id_hazard_reset = 1'b1;
                id_ex_hazard_reset = 1'b1;
                state_d            = ST_BR_FLUSH;
                flush_count_d      = sat_inc(flush_count_q);
            end else if (load_use) begin
                // Freeze PC and IF/ID, and insert a bubble into ID/EX.
                pc_load_enable     = 1'b0;
                if_id_load_enable  = 1'b0;
                id_ex_hazard_reset = 1'b1;
                state_d            = ST_LU_STALL;
                stall_count_d      = sat_inc(stall_count_q);
            end
        end
    end

    // Hazard state and event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign hazard_state = state_q;
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed scoreboard bench for hazard_forwarding_unit.
module tb_hazard_forwarding_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [4:0]  ex_rw, mem_rw, wb_rw;
    logic        ex_rf_enable, mem_rf_enable, wb_rf_enable;
    logic        ex_load, ex_branch_taken;
    logic        pc_load_enable, if_id_load_enable;
    logic        if_id_hazard_reset, id_ex_hazard_reset;
    logic [1:0]  fwd_a_sel, fwd_b_sel, hazard_state;
    logic [15:0] stall_count, flush_count;

    hazard_forwarding_unit dut (
        .clk                (clk),
        .reset              (reset),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_use_rs1         (id_use_rs1),
        .id_use_rs2         (id_use_rs2),
        .ex_rw              (ex_rw),
        .mem_rw             (mem_rw),
        .wb_rw              (wb_rw),
        .ex_rf_enable       (ex_rf_enable),
        .mem_rf_enable      (mem_rf_enable),
        .wb_rf_enable       (wb_rf_enable),
        .ex_load            (ex_load),
        .ex_branch_taken    (ex_branch_taken),
        .pc_load_enable     (pc_load_enable),
        .if_id_load_enable  (if_id_load_enable),
        .if_id_hazard_reset (if_id_hazard_reset),
        .id_ex_hazard_reset (id_ex_hazard_reset),
        .fwd_a_sel          (fwd_a_sel),
        .fwd_b_sel          (fwd_b_sel),
        .hazard_state       (hazard_state),
        .stall_count        (stall_count),
        .flush_count        (flush_count)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exrw, memrw, wbrw;
        logic       exen, memen, wben;
        logic       ld, br;
    } in_t;

    typedef struct {
        string       name;
        logic        pc, le, ifr, idr;
        logic [1:0]  fa, fb, st;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    in_t  v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t r;
        r.rst = 1'b0; r.rs1 = 5'd0; r.rs2 = 5'd0; r.u1 = 1'b0; r.u2 = 1'b0;
        r.exrw = 5'd0; r.memrw = 5'd0; r.wbrw = 5'd0;
        r.exen = 1'b0; r.memen = 1'b0; r.wben = 1'b0;
        r.ld = 1'b0; r.br = 1'b0;
        return r;
    endfunction

    function automatic exp_t mk(string n, logic pc, logic le, logic ifr, logic idr,
                                logic [1:0] fa, logic [1:0] fb, logic [1:0] st,
                                logic [15:0] sc, logic [15:0] fc);
        exp_t e;
        e.name = n; e.pc = pc; e.le = le; e.ifr = ifr; e.idr = idr;
        e.fa = fa; e.fb = fb; e.st = st; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    task automatic apply(input in_t a);
        reset = a.rst; id_rs1 = a.rs1; id_rs2 = a.rs2;
        id_use_rs1 = a.u1; id_use_rs2 = a.u2;
        ex_rw = a.exrw; mem_rw = a.memrw; wb_rw = a.wbrw;
        ex_rf_enable = a.exen; mem_rf_enable = a.memen; wb_rf_enable = a.wben;
        ex_load = a.ld; ex_branch_taken = a.br;
    endtask

    // Drive one cycle's inputs just after the edge and queue the expectation.
    task automatic drive(input in_t a, input exp_t e);
        @(posedge clk);
        #1;
        apply(a);
        q.push_back(e);
    endtask

    task automatic chk(input string n, input string f, input logic [15:0] act,
                       input logic [15:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            chk(e.name, "pc_load_enable",     {15'd0, pc_load_enable},     {15'd0, e.pc});
            chk(e.name, "if_id_load_enable",  {15'd0, if_id_load_enable},  {15'd0, e.le});
            chk(e.name, "if_id_hazard_reset", {15'd0, if_id_hazard_reset}, {15'd0, e.ifr});
            chk(e.name, "id_ex_hazard_reset", {15'd0, id_ex_hazard_reset}, {15'd0, e.idr});
            chk(e.name, "fwd_a_sel",          {14'd0, fwd_a_sel},          {14'd0, e.fa});
            chk(e.name, "fwd_b_sel",          {14'd0, fwd_b_sel},          {14'd0, e.fb});
            chk(e.name, "hazard_state",       {14'd0, hazard_state},       {14'd0, e.st});
            chk(e.name, "stall_count",        stall_count,                 e.sc);
            chk(e.name, "flush_count",        flush_count,                 e.fc);
        end
    end

    initial begin
        v = idle();
        v.rst = 1'b1;
        apply(v);

        // V1: reset dominates a simultaneous branch and load-use
        v = idle(); v.rst = 1'b1; v.br = 1'b1; v.ld = 1'b1;
        v.exrw = 5'd7; v.exen = 1'b1; v.rs1 = 5'd7; v.u1 = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b1;
        drive(v, mk("v1_reset_a", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0));
        drive(v, mk("v1_reset_b", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0));
        v = idle();
        drive(v, mk("idle_after_reset", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0));

        // V2: forwarding priority
        v = idle(); v.rs1 = 5'd5; v.u1 = 1'b1; v.exrw = 5'd5; v.exen = 1'b1;
        v.memrw = 5'd5; v.memen = 1'b1;
        drive(v, mk("v2_ex_over_mem", 1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 16'd0, 16'd0));
        v.exen = 1'b0;
        drive(v, mk("v2_mem", 1, 1, 0, 0, 2'b10, 2'b00, 2'b00, 16'd0, 16'd0));
        v = idle(); v.rs1 = 5'd5; v.u1 = 1'b1; v.rs2 = 5'd5; v.u2 = 1'b0;
        v.wbrw = 5'd5; v.wben = 1'b1;
        drive(v, mk("v2_wb_and_unused_b", 1, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0));
        v = idle(); v.u1 = 1'b1; v.u2 = 1'b1; v.exen = 1'b1; v.memen = 1'b1; v.wben = 1'b1;
        drive(v, mk("v2_r0_never", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0));
        v = idle(); v.rs1 = 5'd3; v.u1 = 1'b1; v.exrw = 5'd3; v.exen = 1'b1;
        v.rs2 = 5'd9; v.u2 = 1'b1; v.memrw = 5'd9; v.memen = 1'b1; v.wbrw = 5'd9; v.wben = 1'b1;
        drive(v, mk("v2_b_mem_over_wb", 1, 1, 0, 0, 2'b01, 2'b10, 2'b00, 16'd0, 16'd0));

        // V3: load-use stall for one cycle
        v = idle(); v.ld = 1'b1; v.exrw = 5'd7; v.exen = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b1;
        drive(v, mk("v3_stall", 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 16'd0, 16'd0));
        v = idle();
        drive(v, mk("v3_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, 16'd1, 16'd0));
        drive(v, mk("v3_back_run", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd1, 16'd0));

        // V4: branch overrides simultaneous load-use
        v = idle(); v.ld = 1'b1; v.exrw = 5'd7; v.exen = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b1;
        v.br = 1'b1;
        drive(v, mk("v4_flush", 1, 1, 1, 1, 2'b00, 2'b01, 2'b00, 16'd1, 16'd0));
        v = idle();
        drive(v, mk("v4_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b10, 16'd1, 16'd1));
        drive(v, mk("v4_back_run", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd1, 16'd1));

        // V5: load writing r0 never stalls; unused operand never stalls
        v = idle(); v.ld = 1'b1; v.exrw = 5'd0; v.exen = 1'b1; v.rs1 = 5'd0; v.u1 = 1'b1;
        drive(v, mk("v5_r0_load", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd1, 16'd1));
        v = idle(); v.ld = 1'b1; v.exrw = 5'd7; v.exen = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b0;
        drive(v, mk("v5_unused_rs2", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd1, 16'd1));
        v = idle();
        drive(v, mk("v5_idle", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd1, 16'd1));

        // Reset during a load-use: idle outputs now, counters cleared next edge
        v = idle(); v.rst = 1'b1; v.ld = 1'b1; v.exrw = 5'd7; v.exen = 1'b1;
        v.rs2 = 5'd7; v.u2 = 1'b1;
        drive(v, mk("reset_mid_stall", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd1, 16'd1));
        v = idle();
        drive(v, mk("reset_discard", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0));

        // V6: long stall run to 16'hFFFE, then saturation
        v = idle(); v.ld = 1'b1; v.exrw = 5'd4; v.exen = 1'b1; v.rs1 = 5'd4; v.u1 = 1'b1;
        drive(v, mk("v6_start", 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 16'd0, 16'd0));
        repeat (65533) @(posedge clk);
        drive(v, mk("v6_fffe", 0, 0, 0, 1, 2'b01, 2'b00, 2'b01, 16'hFFFE, 16'd0));
        drive(v, mk("v6_ffff", 0, 0, 0, 1, 2'b01, 2'b00, 2'b01, 16'hFFFF, 16'd0));
        drive(v, mk("v6_hold", 0, 0, 0, 1, 2'b01, 2'b00, 2'b01, 16'hFFFF, 16'd0));
        v = idle();
        drive(v, mk("v6_hold_idle", 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, 16'hFFFF, 16'd0));
        drive(v, mk("v6_run", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'hFFFF, 16'd0));

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
